pattern_scan_ctrl: RTL and testbench
====================================

PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 Parameter MAX_LEN, default 8: maximum pattern length in bits; legal range 2..16.
REQ-002 Parameter CNT_W, default 8: width of the match counter and the target count.
REQ-003 clk  input  1  system clock; all sequential logic is rising-edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 cfg_we  input  1  configuration write strobe.
REQ-006 cfg_pattern  input  MAX_LEN  pattern to detect; bit [cfg_len-1] is the first serial bit received, bit [0] the last.
REQ-007 cfg_len  input  $clog2(MAX_LEN)+1  pattern length in bits.
REQ-008 cfg_target  input  CNT_W  number of matches that ends a scan; 0 means unlimited.
REQ-009 start  input  1  one-cycle request to begin a scan.
REQ-010 abort  input  1  terminates a scan without asserting done.
REQ-011 x_inp  input  1  serial data bit.
REQ-012 x_valid  input  1  x_inp is sampled only in cycles where x_valid is 1.
REQ-013 busy  output  1  high while the FSM is in the SCAN state.
REQ-014 done  output  1  one-cycle pulse when the target count is reached.
REQ-015 y_out  output  1  one-cycle registered match pulse.
REQ-016 match_cnt  output  CNT_W  matches counted in the current or most recent scan.

Function
REQ-017 FSM states: IDLE, SCAN, FINISH; state encoding is registered.
REQ-018 Configuration registers load on cfg_we in IDLE only; cfg_we is ignored in SCAN and FINISH.
REQ-019 Effective length: a loaded cfg_len of 0 is stored as 1; a cfg_len greater than MAX_LEN is stored as MAX_LEN.
REQ-020 IDLE -> SCAN on start: clear the history shift register, the fill counter and match_cnt in the same edge.
REQ-021 start while busy is ignored.
REQ-022 In SCAN, each valid cycle shifts x_inp into history bit 0, and the fill counter increments, saturating at MAX_LEN.
REQ-023 Match condition: after the shift, fill >= len and history[len-1:0] == pattern[len-1:0].
REQ-024 y_out asserts on the clock edge that samples the completing bit and deasserts on the next edge, unless that edge is itself another match.
REQ-025 On a match, match_cnt increments; it saturates at 2^CNT_W-1 and does not wrap.
REQ-026 SCAN -> FINISH on the edge where match_cnt becomes equal to a nonzero target.
REQ-027 FINISH: done=1 and busy=0 for exactly one cycle, then the FSM goes to IDLE unconditionally.
REQ-028 Bits presented while in FINISH or IDLE are not sampled.
REQ-029 abort in SCAN -> IDLE on the next edge with no done; match_cnt holds its value.
REQ-030 abort and a target-reaching match in the same cycle: the match counts and y_out pulses, abort wins, and done does not pulse.
REQ-031 abort in IDLE or FINISH has no effect.
REQ-032 x_valid=0 cycles do not change history, fill, or y_out, apart from y_out's mandatory fall.

Reset
REQ-033 rst low asynchronously forces the following: state=IDLE, busy=0, done=0, y_out=0, match_cnt=0, history=0, fill=0.
REQ-034 rst low also sets the configuration registers to pattern = all ones, len=3, target=0.
REQ-035 Reset asserted mid-scan discards the scan; no done is produced.
REQ-036 Reset release is synchronous-safe; the first start is honored no earlier than the first edge after rst goes high.

Configuration
REQ-037 Macro PATTERN_SCAN_OVERLAP_EN defined: on a match, history and fill are retained, so overlapping matches are counted.
REQ-038 Macro PATTERN_SCAN_OVERLAP_EN undefined: on a match, history and fill are cleared in the same edge, so matches are non-overlapping.

Verification
REQ-039 Default config (111, len 3), target=2, start, then valid bits 1,1,1,1: with OVERLAP_EN, y_out pulses after bits 3 and 4, match_cnt=2, and done pulses on the cycle after bit 4. Without OVERLAP_EN, only one match is counted and busy stays 1.
REQ-040 Pattern 1011, len 4, target=0, stream 0,1,0,1,1,0,1,1 then abort: with OVERLAP_EN, match_cnt=2; after abort the FSM returns to IDLE with no done.
REQ-041 cfg_we with len=0 then len=MAX_LEN+3: the stored len reads back as effective 1, then MAX_LEN; pattern 1 with len 1 gives y_out on every valid 1.
REQ-042 Drive rst low during SCAN after 2 matches: all outputs go to 0 immediately without a clock, and no done appears after release.
REQ-043 Target reached in the same cycle as abort: y_out=1, match_cnt=target, done never asserts, and the FSM is in IDLE on the next cycle.
REQ-044 Target=255 with a sustained matching stream: match_cnt saturates at 255 and done fires once. Also, cfg_we during SCAN leaves the pattern unchanged.

Source files
------------

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: serial pattern detector with a scan FSM (IDLE/SCAN/FINISH),
// a saturating match counter and an optional target count that ends a scan.
// Optional feature macro: PATTERN_SCAN_OVERLAP_EN keeps the history on a match
// so that overlapping occurrences are counted; undefined, matches do not overlap.
`timescale 1ns/1ps
module pattern_scan_ctrl #(
   parameter int unsigned MAX_LEN = 8,
   parameter int unsigned CNT_W   = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_we,
   input  logic [MAX_LEN-1:0]       cfg_pattern,
   input  logic [$clog2(MAX_LEN):0] cfg_len,
   input  logic [CNT_W-1:0]         cfg_target,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     x_inp,
   input  logic                     x_valid,
   output logic                     busy,
   output logic                     done,
   output logic                     y_out,
   output logic [CNT_W-1:0]         match_cnt
);

   localparam int unsigned LEN_W = $clog2(MAX_LEN) + 1;
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SCAN   = 2'd1;
   localparam logic [1:0] ST_FINISH = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [MAX_LEN-1:0] pat_q;
   logic [LEN_W-1:0]   len_q;
   logic [CNT_W-1:0]   target_q;
   logic [MAX_LEN-1:0] hist_q;
   logic [LEN_W-1:0]   fill_q;
   logic [CNT_W-1:0]   cnt_q;

   logic [MAX_LEN-1:0] hist_shift;
   logic [LEN_W-1:0]   fill_inc;
   logic [MAX_LEN-1:0] len_mask;
   logic [CNT_W-1:0]   cnt_inc;
   logic               sample;
   logic               match;
   logic               hit_target;
   logic               scan_start;

   assign busy      = (state_q == ST_SCAN);
   assign done      = (state_q == ST_FINISH);
   assign match_cnt = cnt_q;

   assign scan_start = (state_q == ST_IDLE) && start;
   assign sample     = (state_q == ST_SCAN) && x_valid;
   assign hist_shift = {hist_q[MAX_LEN-2:0], x_inp};
   assign fill_inc   = (fill_q == LEN_MAX) ? fill_q : fill_q + 1'b1;
   assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

   // Build a mask covering the low len_q bits of the history and pattern
   always_comb begin
      len_mask = '0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
         len_mask[i] = (LEN_W'(i) < len_q);
      end
   end

   assign match      = sample && (fill_inc >= len_q) &&
                       (((hist_shift ^ pat_q) & len_mask) == '0);
   assign hit_target = match && (target_q != '0) && (cnt_inc == target_q);

   // Next-state logic; abort takes priority over reaching the target
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_SCAN;
         ST_SCAN: begin
            if (abort)           state_d = ST_IDLE;
            else if (hit_target) state_d = ST_FINISH;
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // Configuration registers, writable only while idle; length is clamped to 1..MAX_LEN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pat_q    <= '1;
         len_q    <= LEN_W'(3);
         target_q <= '0;
      end else if (cfg_we && (state_q == ST_IDLE)) begin
         pat_q    <= cfg_pattern;
         target_q <= cfg_target;
         if (cfg_len == '0)          len_q <= LEN_W'(1);
         else if (cfg_len > LEN_MAX) len_q <= LEN_MAX;
         else                        len_q <= cfg_len;
      end
   end

   // Serial history, fill level, match counter and registered match pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist_q <= '0;
         fill_q <= '0;
         cnt_q  <= '0;
         y_out  <= 1'b0;
      end else begin
         y_out <= match;
         if (scan_start) begin
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
         end else if (sample) begin
            if (match) cnt_q <= cnt_inc;
`ifdef PATTERN_SCAN_OVERLAP_EN
            hist_q <= hist_shift;
            fill_q <= fill_inc;
`else
            if (match) begin
               hist_q <= '0;
               fill_q <= '0;
            end else begin
               hist_q <= hist_shift;
               fill_q <= fill_inc;
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Testbench for pattern_scan_ctrl: a behavioural model predicts each cycle's
// outputs, the prediction is queued when stimulus is driven and compared
// after the clock edge that produces it.
`timescale 1ns/1ps
module tb_pattern_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_we;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic [7:0] cfg_target;
   logic       start, abort, x_inp, x_valid;
   logic       busy, done, y_out;
   logic [7:0] match_cnt;

   pattern_scan_ctrl #(.MAX_LEN(8), .CNT_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_we      (cfg_we),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_target  (cfg_target),
      .start       (start),
      .abort       (abort),
      .x_inp       (x_inp),
      .x_valid     (x_valid),
      .busy        (busy),
      .done        (done),
      .y_out       (y_out),
      .match_cnt   (match_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       y;
      logic       busy;
      logic       done;
      logic [7:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // model state: 0 idle, 1 scan, 2 finish
   int m_state, m_hist, m_fill, m_cnt, m_pat, m_len, m_tgt;
   bit m_y;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_state = 0; m_hist = 0; m_fill = 0; m_cnt = 0; m_y = 0;
      m_pat = 'hFF; m_len = 3; m_tgt = 0;
   endfunction

   function automatic void model_step(input bit s, input bit a, input bit v, input bit x,
                                      input bit we, input int pat, input int len, input int tgt);
      bit matched = 0;
      if (!rst) begin
         model_reset();
         return;
      end
      case (m_state)
         0: begin
            if (we) begin
               m_pat = pat;
               m_len = (len == 0) ? 1 : (len > 8) ? 8 : len;
               m_tgt = tgt;
            end
            if (s) begin
               m_state = 1; m_hist = 0; m_fill = 0; m_cnt = 0;
            end
         end
         1: begin
            if (v) begin
               m_hist = ((m_hist << 1) | int'(x)) & 'hFF;
               m_fill = (m_fill < 8) ? m_fill + 1 : 8;
               if (m_fill >= m_len &&
                   (m_hist % (1 << m_len)) == (m_pat % (1 << m_len))) begin
                  matched = 1;
                  if (m_cnt < 255) m_cnt++;
`ifndef PATTERN_SCAN_OVERLAP_EN
                  m_hist = 0;
                  m_fill = 0;
`endif
               end
            end
            if (a) m_state = 0;
            else if (matched && m_tgt != 0 && m_cnt == m_tgt) m_state = 2;
         end
         default: m_state = 0;
      endcase
      m_y = matched;
   endfunction

   // One clock cycle: drive, predict, then compare after the edge
   task automatic cyc(input bit s, input bit a, input bit v, input bit x,
                      input bit we, input int pat, input int len, input int tgt);
      exp_t e;
      @(negedge clk);
      start = s; abort = a; x_valid = v; x_inp = x; cfg_we = we;
      cfg_pattern = pat[7:0]; cfg_len = len[3:0]; cfg_target = tgt[7:0];
      model_step(s, a, v, x, we, pat, len, tgt);
      e.y = m_y; e.busy = (m_state == 1); e.done = (m_state == 2); e.cnt = m_cnt[7:0];
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_eq("y_out", int'(y_out), int'(e.y));
      check_eq("busy", int'(busy), int'(e.busy));
      check_eq("done", int'(done), int'(e.done));
      check_eq("match_cnt", int'(match_cnt), int'(e.cnt));
      start = 0; abort = 0; x_valid = 0; cfg_we = 0;
   endtask

   task automatic bit_in(input bit x);
      cyc(0, 0, 1, x, 0, 0, 0, 0);
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic cfg(input int pat, input int len, input int tgt);
      cyc(0, 0, 0, 0, 1, pat, len, tgt);
   endtask

   task automatic go();
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic stop();
      cyc(0, 1, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int bits [8];
      rst = 0; cfg_we = 0; cfg_pattern = 0; cfg_len = 0; cfg_target = 0;
      start = 0; abort = 0; x_inp = 0; x_valid = 0;
      model_reset();
      #1;
      check_eq("rst_y_out", int'(y_out), 0);
      check_eq("rst_busy", int'(busy), 0);
      check_eq("rst_done", int'(done), 0);
      check_eq("rst_match_cnt", int'(match_cnt), 0);
      @(negedge clk); @(negedge clk);
      rst = 1;
      idle_n(1);

      // default pattern 111 without reconfiguration, unlimited target
      go();
      for (int i = 0; i < 4; i++) bit_in(1);
      stop();
      idle_n(1);

      // 111 len 3 target 2, four ones
      cfg('h07, 3, 2);
      go();
      for (int i = 0; i < 4; i++) bit_in(1);
      idle_n(3);
      stop();

      // 1011 len 4 unlimited, stream 0,1,0,1,1,0,1,1 then abort
      cfg('h0B, 4, 0);
      go();
      bits = '{0, 1, 0, 1, 1, 0, 1, 1};
      foreach (bits[i]) bit_in(bits[i][0]);
      stop();
      idle_n(2);

      // len 0 clamps to 1; pattern 1 matches every sampled 1
      cfg('h01, 0, 0);
      go();
      bit_in(1); bit_in(1); bit_in(0);
      cyc(0, 0, 0, 1, 0, 0, 0, 0);
      bit_in(1);
      stop();

      // len MAX_LEN+3 clamps to 8
      cfg('hA5, 11, 0);
      go();
      for (int r = 0; r < 2; r++)
         for (int i = 7; i >= 0; i--) bit_in(((8'hA5 >> i) & 1) != 0);
      stop();

      // async reset mid-scan after matches
      cfg('h07, 3, 0);
      go();
      for (int i = 0; i < 6; i++) bit_in(1);
      #3 rst = 0;
      #1;
      check_eq("async_y_out", int'(y_out), 0);
      check_eq("async_busy", int'(busy), 0);
      check_eq("async_done", int'(done), 0);
      check_eq("async_match_cnt", int'(match_cnt), 0);
      model_reset();
      idle_n(2);
      @(negedge clk);
      rst = 1;
      idle_n(3);

      // start right after release, then target reached together with abort
      go();
      stop();
      cfg('h07, 3, 1);
      go();
      bit_in(1); bit_in(1);
      cyc(0, 1, 1, 1, 0, 0, 0, 0);
      idle_n(2);

      // saturation with unlimited target
      cfg('h01, 1, 0);
      go();
      for (int i = 0; i < 300; i++) cyc(0, 0, (i % 7) != 6, 1, 0, 0, 0, 0);
      stop();

      // target 255, config write during scan must be ignored
      cfg('h01, 1, 255);
      go();
      cyc(0, 0, 1, 1, 1, 'h00, 1, 0);
      for (int i = 0; i < 260; i++) bit_in(1);
      idle_n(2);

      check_eq("scoreboard_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
